// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-unit state encoding and default constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned STEP_DEF = 4;
  localparam int unsigned ALIGN_BITS_DEF = 2;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; overflow overwrites the oldest entry
module pc_ras #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             swap_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] top_o,
  output logic             empty_o,
  output logic             full_o
);
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_up;
  logic [CW-1:0] r_cnt;
  assign w_ptr_up = r_ptr + PW'(1);
  assign top_o = r_mem[r_ptr];
  assign empty_o = r_cnt == '0;
  assign full_o = r_cnt == CW'(RAS_DEPTH);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ptr <= push_i ? w_ptr_up : pop_i ? r_ptr - PW'(1) : r_ptr;
      r_cnt <= (push_i && !full_o) ? r_cnt + CW'(1) : pop_i ? r_cnt - CW'(1) : r_cnt;
    end
  // Entries need no reset: the count gates every read that matters
  always_ff @(posedge clk_i)
    if (push_i) r_mem[w_ptr_up] <= wdata_i;
    else if (swap_i) r_mem[r_ptr] <= wdata_i;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: IF-stage fetch address generator with redirect, stall and call/return via RAS
module pc_fetch_unit import cpu_pkg::*; #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
  parameter int unsigned STEP = STEP_DEF,
  parameter int unsigned ALIGN_BITS = ALIGN_BITS_DEF,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             fetch_ready_i,
  input  logic             redirect_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_valid_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             misalign_o
);
  pc_state_t r_state;
  logic [WIDTH-1:0] r_pc, w_next, w_seq, w_top, w_mask;
  logic w_run, w_adv, w_do_ret, w_do_call, w_load, w_mis, w_empty;
  always_comb begin
    w_run = r_state == RUN;
    w_adv = fetch_ready_i & ~stall_i;
    w_seq = r_pc + WIDTH'(STEP);
    w_mask = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);
    w_do_ret = w_run & ~redirect_i & w_adv & ret_i & ~w_empty;
    w_do_call = w_run & ~redirect_i & w_adv & call_i & ~w_do_ret;
    w_load = w_run & (redirect_i | w_do_ret | w_do_call);
    w_next = redirect_i ? target_i : !w_adv ? r_pc : w_do_ret ? w_top : w_do_call ? target_i : w_seq;
    w_mis = w_load & |(w_next & w_mask);
  end
  // A combined call+ret swaps the top entry instead of popping and pushing
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push_i(w_do_call),
    .pop_i(w_do_ret & ~call_i),
    .swap_i(w_do_ret & call_i),
    .wdata_i(w_seq),
    .top_o(w_top),
    .empty_o(w_empty),
    .full_o(ras_full_o)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_state <= IDLE;
      r_pc <= RESET_PC;
    end else begin
      r_state <= (r_state == IDLE && start_i) ? RUN : w_mis ? HALT : r_state;
      r_pc <= w_run ? w_next : r_pc;
    end
  assign pc_o = r_pc;
  assign pc_valid_o = r_state == RUN;
  assign misalign_o = r_state == HALT;
  assign ras_empty_o = w_empty;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed plan plus randomized run against a queue-based reference model
module tb_pc_fetch_unit;
  logic clk_i = 1'b0;
  logic rst_i, start_i, stall_i, fetch_ready_i, redirect_i, call_i, ret_i;
  logic [31:0] target_i, pc_o;
  logic pc_valid_o, ras_empty_o, ras_full_o, misalign_o;
  int total = 0;
  int bad = 0;
  int m_st;
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];

  pc_fetch_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .fetch_ready_i(fetch_ready_i), .redirect_i(redirect_i), .call_i(call_i),
    .ret_i(ret_i), .target_i(target_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc_o, m_pc);
    chk({tag, ".valid"}, 32'(pc_valid_o), 32'(m_st == 1));
    chk({tag, ".empty"}, 32'(ras_empty_o), 32'(m_ras.size() == 0));
    chk({tag, ".full"}, 32'(ras_full_o), 32'(m_ras.size() == 4));
    chk({tag, ".misalign"}, 32'(misalign_o), 32'(m_st == 2));
  endtask

  task automatic model_rst();
    m_st = 0;
    m_pc = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    logic ld;
    ld = 1'b0;
    nxt = m_pc;
    if (m_st == 0) begin
      if (start_i) m_st = 1;
    end else if (m_st == 1) begin
      if (redirect_i) begin
        nxt = target_i;
        ld = 1'b1;
      end else if (!(fetch_ready_i && !stall_i)) begin
        nxt = m_pc;
      end else if (ret_i && m_ras.size() > 0) begin
        nxt = m_ras[$];
        ld = 1'b1;
        if (call_i) m_ras[m_ras.size() - 1] = m_pc + 32'd4;
        else void'(m_ras.pop_back());
      end else if (call_i) begin
        nxt = target_i;
        ld = 1'b1;
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else begin
        nxt = m_pc + 32'd4;
      end
      if (ld && nxt[1:0] != 2'b00) m_st = 2;
      m_pc = nxt;
    end
  endtask

  task automatic drive(input logic st, input logic sl, input logic fr, input logic rd,
                       input logic cl, input logic rt, input logic [31:0] tg);
    start_i = st; stall_i = sl; fetch_ready_i = fr;
    redirect_i = rd; call_i = cl; ret_i = rt; target_i = tg;
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    rst_i = 1'b1;
    #2;
    model_rst();
    check_all(tag);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    rst_i = 1'b1;
    model_rst();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_all("reset");
    drive(0, 0, 1, 1, 1, 0, 32'h40);
    cyc("idle_ignore");
    // plan 1: start then sequential fetch
    drive(1, 0, 1, 0, 0, 0, 32'h0);
    cyc("start");
    chk("t1_pc0", pc_o, 32'h0);
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    cyc("seq1");
    chk("t1_pc1", pc_o, 32'h4);
    cyc("seq2");
    chk("t1_pc2", pc_o, 32'h8);
    // plan 2: stall hold with redirect on last stall cycle
    drive(0, 0, 1, 1, 0, 0, 32'h10);
    cyc("to10");
    drive(0, 1, 1, 0, 0, 0, 32'h0);
    cyc("stall1");
    cyc("stall2");
    chk("t2_hold", pc_o, 32'h10);
    drive(0, 1, 1, 1, 0, 0, 32'h80);
    cyc("stall_redir");
    chk("t2_redir", pc_o, 32'h80);
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    cyc("after_redir");
    chk("t2_next", pc_o, 32'h84);
    // plan 3: single call and return
    drive(0, 0, 1, 1, 0, 0, 32'h20);
    cyc("to20");
    drive(0, 0, 1, 0, 1, 0, 32'h100);
    cyc("call");
    chk("t3_call_pc", pc_o, 32'h100);
    chk("t3_nonempty", 32'(ras_empty_o), 32'h0);
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    cyc("c_seq1");
    cyc("c_seq2");
    drive(0, 0, 1, 0, 0, 1, 32'h0);
    cyc("ret");
    chk("t3_ret_pc", pc_o, 32'h24);
    chk("t3_empty", 32'(ras_empty_o), 32'h1);
    // plan 4: overflow the RAS, then drain past empty
    drive(0, 0, 1, 1, 0, 0, 32'h0);
    cyc("to0");
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 1, 0, 1, 0, 32'(i * 256));
      cyc("deep_call");
    end
    chk("t4_full", 32'(ras_full_o), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      drive(0, 0, 1, 0, 0, 1, 32'h0);
      cyc("deep_ret");
      chk("t4_ret_pc", pc_o, 32'(i * 256 + 4));
    end
    cyc("fallthru");
    chk("t4_fall_pc", pc_o, 32'h108);
    // plan 6 (wrap and async reset with a full RAS)
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 1, 0, 32'h200);
      cyc("fill");
    end
    drive(0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    cyc("to_top");
    drive(0, 0, 1, 0, 0, 0, 32'h0);
    cyc("wrap");
    chk("t6_wrap", pc_o, 32'h0);
    drive(0, 0, 1, 1, 0, 0, 32'hFFFF_FFFC);
    cyc("to_top2");
    chk("t6_full", 32'(ras_full_o), 32'h1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("t6_arst_pc", pc_o, 32'h0);
    chk("t6_arst_valid", 32'(pc_valid_o), 32'h0);
    chk("t6_arst_empty", 32'(ras_empty_o), 32'h1);
    model_rst();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_all("post_arst");
    // plan 5: misaligned redirect halts until reset
    drive(1, 0, 1, 0, 0, 0, 32'h0);
    cyc("start2");
    drive(0, 0, 1, 1, 0, 0, 32'h42);
    cyc("misalign");
    chk("t5_pc", pc_o, 32'h42);
    chk("t5_mis", 32'(misalign_o), 32'h1);
    drive(1, 0, 1, 1, 1, 0, 32'h300);
    cyc("halt1");
    drive(1, 0, 1, 0, 0, 1, 32'h0);
    cyc("halt2");
    chk("t5_hold", pc_o, 32'h42);
    do_reset("rst_halt");
    // randomized run
    drive(1, 0, 1, 0, 0, 0, 32'h0);
    cyc("rstart");
    for (int n = 0; n < 3000; n++) begin
      if (m_st == 2 || $urandom_range(0, 199) == 0) do_reset("rnd_rst");
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            ($urandom_range(0, 63) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      cyc("rnd");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Parametrised successor to the single-register program counter. It generates the fetch address for the IF stage of the pipelined CPU, with:
- a start/idle/halt sequencer
- a valid/ready fetch handshake
- load-use stall hold
- EX-stage branch redirect
- call/return target selection backed by a small return-address stack (RAS)

pc_o drives instruction memory; control inputs come from the hazard-detection unit, the EX stage and ID decode.

Parameters:
WIDTH, 32, PC width in bits
RESET_PC, 32'h0000_0000, PC value after reset
STEP, 4, sequential increment in bytes
ALIGN_BITS, 2, low target bits that must be zero
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  leave IDLE and begin fetching
stall_i  in  1  hazard-detect stall; hold PC
fetch_ready_i  in  1  instruction memory accepts pc_o this cycle
redirect_i  in  1  EX-stage branch taken/mispredict; load target_i
call_i  in  1  ID-decoded call; jump to target_i, push return address
ret_i  in  1  ID-decoded return; jump to RAS top
target_i  in  WIDTH  redirect/call target
pc_o  out  WIDTH  current fetch address
pc_valid_o  out  1  pc_o is a valid fetch request
ras_empty_o  out  1  RAS holds no entries
ras_full_o  out  1  RAS holds RAS_DEPTH entries
misalign_o  out  1  sticky: misaligned target taken, unit halted

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - pc_o=RESET_PC, state=IDLE, pc_valid_o=0, misalign_o=0
  - RAS count=0, so ras_empty_o=1 and ras_full_o=0
- States: IDLE, RUN, HALT. All outputs are registered, with 1-cycle latency from input to effect.
- IDLE:
  - pc_o holds RESET_PC, pc_valid_o=0, all controls ignored.
  - start_i=1 -> RUN; pc_valid_o=1 the next cycle with pc_o=RESET_PC.
- RUN: pc_valid_o=1, start_i ignored. Define adv = fetch_ready_i & ~stall_i. Priority per cycle:
  1. redirect_i=1: pc_o<=target_i regardless of stall_i/fetch_ready_i. call_i/ret_i are ignored (their instruction is being flushed). RAS is unchanged.
  2. adv=0: pc_o holds, RAS holds.
  3. ret_i & call_i with RAS non-empty: pc_o<=RAS top; the top entry is replaced by pc_o+STEP; count is unchanged.
  4. ret_i & call_i with RAS empty: treated as call.
  5. ret_i only, RAS non-empty: pc_o<=top, then pop.
  6. ret_i only, RAS empty: pc_o<=pc_o+STEP (sequential fall-through), RAS unchanged.
  7. call_i only: pc_o<=target_i, push pc_o+STEP. When full, the push overwrites the oldest entry (circular) and count stays at RAS_DEPTH.
  8. Otherwise: pc_o<=pc_o+STEP.
- Arithmetic: pc_o+STEP wraps modulo 2^WIDTH (e.g. 32'hFFFF_FFFC -> 32'h0000_0000).
- Misalignment:
  - Applies to any loaded target (target_i or RAS top) with target[ALIGN_BITS-1:0]!=0.
  - Next state is HALT: pc_o takes the faulting target, pc_valid_o=0, misalign_o=1.
- HALT: all inputs ignored; the only exit is rst_i.
- ras_empty_o/ras_full_o are derived from the registered count and update in the same cycle as the push/pop that changes it.

Decomposition:
- Shared package (cpu_pkg):
  - pc_state_t enum {IDLE, RUN, HALT}
  - default constants RESET_PC_DEF, STEP_DEF, ALIGN_BITS_DEF
- One natural sub-module: pc_ras, a circular LIFO.
  - Parameters WIDTH and RAS_DEPTH.
  - Ports: push, pop, swap, wdata, top, empty, full.
  - Wrap-on-overflow pointer plus saturating count.

Test Plan:
1. Reset then start_i=1 for one cycle, fetch_ready_i=1 -> pc_o=0x0, 0x4, 0x8 on successive cycles, pc_valid_o=1 from the cycle after start.
2. RUN at pc_o=0x10, stall_i=1 for 3 cycles, then redirect_i=1 with target_i=0x80 on the last stall cycle -> pc_o holds 0x10 for 2 cycles, then 0x80, then 0x84.
3. call_i with target_i=0x100 at pc_o=0x20; later ret_i at pc_o=0x108 -> pc_o=0x100, then 0x24 after the ret; ras_empty_o goes 0 then back to 1.
4. Five consecutive calls (RAS_DEPTH=4) from pc 0x0, 0x100, 0x200, 0x300, 0x400, with targets 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_full_o=1; four rets return 0x404, 0x304, 0x204, 0x104; a fifth ret falls through to pc+4.
5. redirect_i with target_i=0x42 -> pc_o=0x42, pc_valid_o=0, misalign_o=1 held; start_i/redirect_i afterwards have no effect until rst_i.
6. rst_i asserted asynchronously mid-RUN with a full RAS and pc_o=0xFFFF_FFFC -> immediately pc_o=0x0, pc_valid_o=0, ras_empty_o=1; wrap check: without reset, the next pc after 0xFFFF_FFFC is 0x0.
